rename_recovery_ctrl: RTL and testbench
=======================================

# rename_recovery_ctrl

Sequences rename-state recovery after a mispredicted branch retires. Maintains the retirement map (arch reg → committed phys reg) from ROB retire traffic. On a mispredict it squashes the pipeline, stalls dispatch, and drains in-flight CDB traffic. It then bulk-loads the speculative map table through its `in_mt_en`/`in_mt` port and handshakes a free-list rebuild before releasing dispatch.

## Interface
- `DEPTH`, default `` `ARCH_REG_SZ ``: number of architectural registers.
- `N`, default `` `N ``: superscalar width (retire slots).
- `DRAIN_CYCLES`, default 2: cycles held in DRAIN; legal range 1–7.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `retire_valid` in [N]: slot i retires this cycle.
- `retire_arch_idx` in REG_IDX[N]: arch dest of retiring instruction.
- `retire_phys_idx` in PHYS_REG_IDX[N]: committed phys dest.
- `retire_mispredict` in [N]: slot i is a mispredicted branch; qualified by `retire_valid[i]`.
- `fl_restore_done` in 1: free list finished rebuild.
- `squash` out 1: pipeline flush pulse to ROB/RS/FUs.
- `dispatch_stall` out 1: blocks rename/dispatch.
- `mt_restore_en` out 1: drives map table `in_mt_en`.
- `mt_restore_data` out MAP_TABLE_PACKET[DEPTH]: drives map table `in_mt`.
- `fl_restore_req` out 1: one-cycle request to rebuild the free list from `rrat_out`.
- `rrat_out` out MAP_TABLE_PACKET[DEPTH]: current retirement map.
- `state_dbg` out RECOV_STATE: FSM state (DEBUG).

## Operation
- Retirement map update:
  - Let m be the lowest slot with `retire_valid[m] && retire_mispredict[m]`.
  - Slots 0..m write RRAT; slots > m are ignored (squashed).
  - With no mispredict, all valid slots write.
  - A write is `rrat[retire_arch_idx].reg_idx <= retire_phys_idx`, skipped when the arch idx is 0.
  - Several slots writing the same arch reg in one cycle: highest-numbered slot wins.
- RRAT entries always carry ready=1, valid=1.
- FSM states:
  - NORMAL: goes to SQUASH when any qualified mispredict is present.
  - SQUASH: 1 cycle, `squash`=1; then DRAIN.
  - DRAIN: a 3-bit counter loads DRAIN_CYCLES-1 on entry and decrements; goes to RESTORE at 0.
  - RESTORE: 1 cycle, `mt_restore_en`=1, `fl_restore_req`=1. Goes to NORMAL if `fl_restore_done`=1 this cycle, else WAIT_FL.
  - WAIT_FL: goes to NORMAL when `fl_restore_done`=1.
- `mt_restore_data`:
  - Each entry is the RRAT entry, with ready=1 and valid=1.
  - Driven combinationally from the RRAT register in every state.
  - Only meaningful while `mt_restore_en`=1.
- `dispatch_stall` = (state != NORMAL) | (any qualified mispredict this cycle).
- `retire_valid` outside NORMAL is a protocol error: inputs are ignored and RRAT is not written. Bench asserts this never occurs.
- `fl_restore_done` outside RESTORE/WAIT_FL is ignored.

## Timing
- Reset:
  - state NORMAL; `rrat[i].reg_idx`=i, ready=1, valid=1.
  - `squash`, `mt_restore_en`, `fl_restore_req`, `dispatch_stall` = 0.
  - Counter = 0.
- Retire in cycle t: RRAT visible on `rrat_out` at t+1.
- Mispredict retires in cycle t:
  - `dispatch_stall` high in t (combinational).
  - RRAT includes slots ≤ m at t+1.
  - `squash` high at t+1.
  - DRAIN at t+2 .. t+1+DRAIN_CYCLES.
  - RESTORE at t+2+DRAIN_CYCLES.
  - Earliest NORMAL at t+3+DRAIN_CYCLES (t+5 at default).
- Map table captures `mt_restore_data` at the RESTORE-cycle edge. RESTORE always follows SQUASH and DRAIN, so it always sees the post-mispredict RRAT.
- `dispatch_stall` stays high through every cycle of WAIT_FL. It drops the cycle after `fl_restore_done` is sampled.
- Reset mid-recovery returns to NORMAL with the identity RRAT, next cycle. No pending request survives.

## Structure
- `sys_defs.svh` gets:
  - typedef enum RECOV_STATE {NORMAL, SQUASH, DRAIN, RESTORE, WAIT_FL};
  - `` `RECOV_DRAIN_CYCLES `` default.
- MAP_TABLE_PACKET, REG_IDX, PHYS_REG_IDX are reused from `sys_defs.svh`.
- One sub-module, `arch_map_table`: DEPTH-entry RRAT with N ordered write ports and a per-slot write mask (mask = slots ≤ m). Exposes the full array.
- The FSM, counter and output decode stay in `rename_recovery_ctrl`.

## Test plan
- Reset, then idle → `rrat_out[5].reg_idx`=5; all control outputs 0; state NORMAL.
- Retire slot0 (arch 3→phys 40) and slot1 (arch 3→phys 41) in one cycle → `rrat[3].reg_idx`=41 next cycle.
- Retire slot0 arch 4→phys 33 with `retire_mispredict[0]`=1, plus slot1 arch 6→phys 34:
  - `rrat[4]`=33, `rrat[6]` unchanged.
  - `squash` one cycle at t+1.
  - `mt_restore_en` at t+4, with `mt_restore_data[4]`={33, ready 1, valid 1}.
- `fl_restore_done` held low 3 cycles after RESTORE → `dispatch_stall` high through WAIT_FL; NORMAL one cycle after done=1.
- `fl_restore_done`=1 during RESTORE → NORMAL at the next edge; `dispatch_stall` low at t+5.
- Assert reset during DRAIN → next cycle NORMAL, identity RRAT, `squash`/`mt_restore_en`/`fl_restore_req` never pulse.

Source files
------------

// File: rtl/rename_recovery_ctrl_pkg.sv
// rename_recovery_ctrl_pkg
//   Shared types and defaults for the rename-recovery slice: register index
//   widths, the map-table entry packet and the recovery FSM state encoding.
package rename_recovery_ctrl_pkg;

  localparam int ARCH_REG_SZ        = 32;
  localparam int PHYS_REG_SZ        = 64;
  localparam int N_WIDTH            = 2;
  localparam int RECOV_DRAIN_CYCLES = 2;

  typedef logic [$clog2(ARCH_REG_SZ)-1:0] REG_IDX;
  typedef logic [$clog2(PHYS_REG_SZ)-1:0] PHYS_REG_IDX;

  typedef struct packed {
    PHYS_REG_IDX reg_idx;
    logic        ready;
    logic        valid;
  } MAP_TABLE_PACKET;

  typedef enum logic [2:0] {
    NORMAL,
    SQUASH,
    DRAIN,
    RESTORE,
    WAIT_FL
  } RECOV_STATE;

endpackage

// File: rtl/rename_recovery_ctrl_if.sv
// rename_recovery_ctrl_if
//   Bundles the retire bus, the free-list handshake and the recovery outputs.
//   slave  : the recovery controller's view (retire/done in, control out).
//   master : the pipeline/testbench view (retire/done out, control in).
interface rename_recovery_ctrl_if
  import rename_recovery_ctrl_pkg::*;
#(
  parameter int DEPTH = ARCH_REG_SZ,
  parameter int N     = N_WIDTH
);
  logic [N-1:0]    retire_valid;
  REG_IDX          retire_arch_idx [N];
  PHYS_REG_IDX     retire_phys_idx [N];
  logic [N-1:0]    retire_mispredict;
  logic            fl_restore_done;

  logic            squash;
  logic            dispatch_stall;
  logic            mt_restore_en;
  MAP_TABLE_PACKET mt_restore_data [DEPTH];
  logic            fl_restore_req;
  MAP_TABLE_PACKET rrat_out [DEPTH];
  RECOV_STATE      state_dbg;

  modport slave (
    input  retire_valid, retire_arch_idx, retire_phys_idx, retire_mispredict,
    input  fl_restore_done,
    output squash, dispatch_stall, mt_restore_en, mt_restore_data,
    output fl_restore_req, rrat_out, state_dbg
  );

  modport master (
    output retire_valid, retire_arch_idx, retire_phys_idx, retire_mispredict,
    output fl_restore_done,
    input  squash, dispatch_stall, mt_restore_en, mt_restore_data,
    input  fl_restore_req, rrat_out, state_dbg
  );
endinterface

// File: rtl/rename_recovery_ctrl_arch_map_table.sv
// arch_map_table
//   Retirement map (arch reg -> committed phys reg) with N ordered write
//   ports. Ports:
//     clock, reset : clock, synchronous active-high reset (identity map)
//     i_wr_en      : per-slot write enable (already masked by the caller)
//     i_wr_arch    : per-slot arch destination
//     i_wr_phys    : per-slot committed phys destination
//     o_rrat       : full map, every entry ready=1 valid=1
module arch_map_table
  import rename_recovery_ctrl_pkg::*;
#(
  parameter int DEPTH = ARCH_REG_SZ,
  parameter int N     = N_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    i_wr_en,
  input  REG_IDX          i_wr_arch [N],
  input  PHYS_REG_IDX     i_wr_phys [N],
  output MAP_TABLE_PACKET o_rrat [DEPTH]
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      PHYS_REG_IDX r_entry;
      PHYS_REG_IDX w_next;

      // Slots are scanned in ascending order so the highest-numbered writer
      // to this arch reg wins. Arch reg 0 is hard-wired and never written.
      always_comb begin
        w_next = r_entry;
        for (int s = 0; s < N; s++) begin
          if (i_wr_en[s] && (i_wr_arch[s] == REG_IDX'(gi)) && (i_wr_arch[s] != '0)) begin
            w_next = i_wr_phys[s];
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          r_entry <= PHYS_REG_IDX'(gi);
        end else begin
          r_entry <= w_next;
        end
      end

      assign o_rrat[gi] = '{reg_idx: r_entry, ready: 1'b1, valid: 1'b1};
    end
  endgenerate

endmodule

// File: rtl/rename_recovery_ctrl.sv
// rename_recovery_ctrl
//   Tracks the retirement map and sequences recovery after a mispredicted
//   branch retires: SQUASH (flush pulse), DRAIN (let CDB traffic settle),
//   RESTORE (bulk-load the speculative map table, request free-list rebuild),
//   WAIT_FL (hold dispatch until the free list reports done). Ports:
//     clock, reset : clock, synchronous active-high reset
//     bus (slave)  : retire bus + fl_restore_done in; squash, dispatch_stall,
//                    mt_restore_en/data, fl_restore_req, rrat_out,
//                    state_dbg out
//   DRAIN_CYCLES must lie in 1..7 (3-bit drain counter).
module rename_recovery_ctrl
  import rename_recovery_ctrl_pkg::*;
#(
  parameter int DEPTH        = ARCH_REG_SZ,
  parameter int N            = N_WIDTH,
  parameter int DRAIN_CYCLES = RECOV_DRAIN_CYCLES
) (
  input logic                    clock,
  input logic                    reset,
  rename_recovery_ctrl_if.slave  bus
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  RECOV_STATE      r_state;
  logic [2:0]      r_drain_cnt;
  logic            r_squash;
  logic            r_mt_en;
  logic            r_fl_req;

  logic [N-1:0]    w_qual_mp;
  logic            w_any_mp;
  logic [N-1:0]    w_slot_mask;
  logic [N-1:0]    w_wr_en;
  REG_IDX          w_wr_arch [N];
  PHYS_REG_IDX     w_wr_phys [N];
  MAP_TABLE_PACKET w_rrat [DEPTH];

  assign w_qual_mp = bus.retire_valid & bus.retire_mispredict;
  assign w_any_mp  = |w_qual_mp;

  // A slot may write only if no lower slot is a qualified mispredict; the
  // mispredicting slot itself still commits.
  always_comb begin
    w_slot_mask = '0;
    w_slot_mask[0] = 1'b1;
    for (int s = 1; s < N; s++) begin
      w_slot_mask[s] = w_slot_mask[s-1] & ~w_qual_mp[s-1];
    end
  end

  // Retires outside NORMAL are a protocol error and are dropped here.
  assign w_wr_en = bus.retire_valid & w_slot_mask & {N{r_state == NORMAL}};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign w_wr_arch[gi] = bus.retire_arch_idx[gi];
      assign w_wr_phys[gi] = bus.retire_phys_idx[gi];
    end
  endgenerate

  arch_map_table #(
    .DEPTH (DEPTH),
    .N     (N)
  ) u_rrat (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_arch (w_wr_arch),
    .i_wr_phys (w_wr_phys),
    .o_rrat    (w_rrat)
  );

  // Control outputs are registered: each is set on the edge that enters the
  // state it belongs to and cleared by default on every other edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= NORMAL;
      r_drain_cnt <= '0;
      r_squash    <= 1'b0;
      r_mt_en     <= 1'b0;
      r_fl_req    <= 1'b0;
    end else begin
      r_squash <= 1'b0;
      r_mt_en  <= 1'b0;
      r_fl_req <= 1'b0;
      case (r_state)
        NORMAL: begin
          if (w_any_mp) begin
            r_state  <= SQUASH;
            r_squash <= 1'b1;
          end
        end
        SQUASH: begin
          r_state     <= DRAIN;
          r_drain_cnt <= DRAIN_LOAD;
        end
        DRAIN: begin
          if (r_drain_cnt == 3'd0) begin
            r_state  <= RESTORE;
            r_mt_en  <= 1'b1;
            r_fl_req <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
          end
        end
        RESTORE: begin
          r_state <= bus.fl_restore_done ? NORMAL : WAIT_FL;
        end
        WAIT_FL: begin
          if (bus.fl_restore_done) begin
            r_state <= NORMAL;
          end
        end
        default: r_state <= NORMAL;
      endcase
    end
  end

  assign bus.squash         = r_squash;
  assign bus.mt_restore_en  = r_mt_en;
  assign bus.fl_restore_req = r_fl_req;
  assign bus.state_dbg      = r_state;
  // The combinational mispredict term stalls dispatch in the retire cycle
  // itself, before the FSM has left NORMAL.
  assign bus.dispatch_stall = (r_state != NORMAL) | w_any_mp;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
      assign bus.rrat_out[gi]        = w_rrat[gi];
      assign bus.mt_restore_data[gi] = w_rrat[gi];
    end
  endgenerate

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
module tb_rename_recovery_ctrl;
  import rename_recovery_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rename_recovery_ctrl_if bus ();

  rename_recovery_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected map-table packet for a given phys reg: ready=1, valid=1.
  function automatic logic [31:0] pkt(input int phys);
    logic [7:0] p;
    p = {PHYS_REG_IDX'(phys), 1'b1, 1'b1};
    return 32'(p);
  endfunction

  function automatic logic [31:0] st(input RECOV_STATE s);
    return 32'(s);
  endfunction

  task automatic drive_retire(input logic [1:0] v, input logic [1:0] mp,
                              input int a0, input int p0, input int a1, input int p1);
    bus.retire_valid       = v;
    bus.retire_mispredict  = mp;
    bus.retire_arch_idx[0] = REG_IDX'(a0);
    bus.retire_phys_idx[0] = PHYS_REG_IDX'(p0);
    bus.retire_arch_idx[1] = REG_IDX'(a1);
    bus.retire_phys_idx[1] = PHYS_REG_IDX'(p1);
    $display("retire v=%b mp=%b slot0 %0d->%0d slot1 %0d->%0d", v, mp, a0, p0, a1, p1);
  endtask

  task automatic idle();
    bus.retire_valid       = '0;
    bus.retire_mispredict  = '0;
    bus.retire_arch_idx[0] = '0;
    bus.retire_phys_idx[0] = '0;
    bus.retire_arch_idx[1] = '0;
    bus.retire_phys_idx[1] = '0;
  endtask

  // Retires must never be presented while the controller is recovering.
  always begin
    @(negedge clock);
    #2;
    if (!reset) begin
      check_val("no_retire_outside_normal",
                32'((bus.state_dbg != NORMAL) && (|bus.retire_valid)), 32'd0);
    end
  end

  initial begin
    idle();
    bus.fl_restore_done = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check_val("rst_rrat5",  32'(bus.rrat_out[5]), pkt(5));
    check_val("rst_state",  st(bus.state_dbg), st(NORMAL));
    check_val("rst_squash", 32'(bus.squash), 32'd0);
    check_val("rst_mt_en",  32'(bus.mt_restore_en), 32'd0);
    check_val("rst_fl_req", 32'(bus.fl_restore_req), 32'd0);
    check_val("rst_stall",  32'(bus.dispatch_stall), 32'd0);

    // Two slots to the same arch reg: slot1 wins.
    @(negedge clock); drive_retire(2'b11, 2'b00, 3, 40, 3, 41); #1;
    check_val("dup_stall", 32'(bus.dispatch_stall), 32'd0);
    // Arch 0 write ignored; mispredict on an invalid slot is not qualified.
    @(negedge clock); drive_retire(2'b01, 2'b10, 0, 60, 0, 0); #1;
    check_val("dup_rrat3", 32'(bus.rrat_out[3]), pkt(41));
    check_val("unq_stall", 32'(bus.dispatch_stall), 32'd0);
    @(negedge clock); drive_retire(2'b01, 2'b00, 9, 52, 0, 0); #1;
    check_val("arch0_rrat0", 32'(bus.rrat_out[0]), pkt(0));
    @(negedge clock); idle(); #1;
    check_val("rrat9", 32'(bus.rrat_out[9]), pkt(52));
    check_val("unq_state", st(bus.state_dbg), st(NORMAL));

    // Mispredict in slot0; slot1 is squashed. Free list slow to finish.
    @(negedge clock); drive_retire(2'b11, 2'b01, 4, 33, 6, 34); #1;
    check_val("mp_stall_t", 32'(bus.dispatch_stall), 32'd1);
    check_val("mp_state_t", st(bus.state_dbg), st(NORMAL));
    @(negedge clock); idle(); #1;
    check_val("mp_squash_t1", 32'(bus.squash), 32'd1);
    check_val("mp_state_t1",  st(bus.state_dbg), st(SQUASH));
    check_val("mp_rrat4",     32'(bus.rrat_out[4]), pkt(33));
    check_val("mp_rrat6",     32'(bus.rrat_out[6]), pkt(6));
    @(negedge clock); #1;
    check_val("mp_squash_t2", 32'(bus.squash), 32'd0);
    check_val("mp_state_t2",  st(bus.state_dbg), st(DRAIN));
    @(negedge clock); #1;
    check_val("mp_state_t3",  st(bus.state_dbg), st(DRAIN));
    check_val("mp_mt_en_t3",  32'(bus.mt_restore_en), 32'd0);
    @(negedge clock); #1;
    check_val("mp_state_t4",  st(bus.state_dbg), st(RESTORE));
    check_val("mp_mt_en_t4",  32'(bus.mt_restore_en), 32'd1);
    check_val("mp_fl_req_t4", 32'(bus.fl_restore_req), 32'd1);
    check_val("mp_mt_data4",  32'(bus.mt_restore_data[4]), pkt(33));
    check_val("mp_mt_data3",  32'(bus.mt_restore_data[3]), pkt(41));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      check_val("wait_state",  st(bus.state_dbg), st(WAIT_FL));
      check_val("wait_stall",  32'(bus.dispatch_stall), 32'd1);
      check_val("wait_fl_req", 32'(bus.fl_restore_req), 32'd0);
    end
    @(negedge clock); bus.fl_restore_done = 1'b1; #1;
    check_val("done_stall", 32'(bus.dispatch_stall), 32'd1);
    @(negedge clock); bus.fl_restore_done = 1'b0; #1;
    check_val("done_state", st(bus.state_dbg), st(NORMAL));
    check_val("done_stall_low", 32'(bus.dispatch_stall), 32'd0);

    // Mispredict in slot1: both slots commit. Done arrives during RESTORE.
    @(negedge clock); drive_retire(2'b11, 2'b10, 7, 50, 8, 51); #1;
    check_val("mp1_stall_t", 32'(bus.dispatch_stall), 32'd1);
    @(negedge clock); idle(); #1;
    check_val("mp1_squash", 32'(bus.squash), 32'd1);
    check_val("mp1_rrat7",  32'(bus.rrat_out[7]), pkt(50));
    check_val("mp1_rrat8",  32'(bus.rrat_out[8]), pkt(51));
    repeat (2) @(negedge clock);
    @(negedge clock); bus.fl_restore_done = 1'b1; #1;
    check_val("fast_state_t4", st(bus.state_dbg), st(RESTORE));
    @(negedge clock); bus.fl_restore_done = 1'b0; #1;
    check_val("fast_state_t5", st(bus.state_dbg), st(NORMAL));
    check_val("fast_stall_t5", 32'(bus.dispatch_stall), 32'd0);
    check_val("fast_mt_en_t5", 32'(bus.mt_restore_en), 32'd0);

    // fl_restore_done in NORMAL is ignored.
    @(negedge clock); bus.fl_restore_done = 1'b1; #1;
    @(negedge clock); bus.fl_restore_done = 1'b0; #1;
    check_val("stray_done_state", st(bus.state_dbg), st(NORMAL));

    // Reset during DRAIN.
    @(negedge clock); drive_retire(2'b01, 2'b01, 10, 53, 0, 0); #1;
    @(negedge clock); idle(); #1;
    check_val("rd_rrat10_pre", 32'(bus.rrat_out[10]), pkt(53));
    @(negedge clock); reset = 1'b1; #1;
    check_val("rd_state_drain", st(bus.state_dbg), st(DRAIN));
    @(negedge clock); reset = 1'b0; #1;
    check_val("rd_state",  st(bus.state_dbg), st(NORMAL));
    check_val("rd_rrat10", 32'(bus.rrat_out[10]), pkt(10));
    check_val("rd_rrat3",  32'(bus.rrat_out[3]), pkt(3));
    check_val("rd_rrat4",  32'(bus.rrat_out[4]), pkt(4));
    check_val("rd_stall",  32'(bus.dispatch_stall), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      check_val("rd_squash", 32'(bus.squash), 32'd0);
      check_val("rd_mt_en",  32'(bus.mt_restore_en), 32'd0);
      check_val("rd_fl_req", 32'(bus.fl_restore_req), 32'd0);
      check_val("rd_state_hold", st(bus.state_dbg), st(NORMAL));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
